// File: rtl/prod_accum_6_pkg.sv
// Shared definitions for the prod_accum_6 block.
//   state_t  : group state machine encoding (IDLE / ACCUM / HOLD)
//   IN_W     : width of the signed result bus coming from adder_6
//   sext_in  : sign-extends an IN_W-bit beat to 64 bits; callers size-cast
//              the result down to their accumulator width
package prod_accum_pkg;

    localparam int IN_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic [63:0] sext_in(input logic [IN_W-1:0] d);
        return {{(64-IN_W){d[IN_W-1]}}, d};
    endfunction

endpackage

// File: rtl/prod_accum_6_if.sv
// Beat input / group output bundle of prod_accum_6.
//   in_valid, in_data, in_last, in_ready : beat stream from adder_6
//   out_valid, out_sum, out_count, out_sat, out_ready : completed group
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. A source holds its payload stable while valid=1 and ready=0;
// ready may depend on state but never on the same-cycle valid.
// The slave modport is the accumulator, the master modport its environment.
interface prod_accum_6_if #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 5
);
    import prod_accum_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );

endinterface

// File: rtl/prod_accum_6_sat_add.sv
// Combinational W-bit signed saturating adder.
//   a, b : signed operands
//   y    : a+b clamped to [-2^(W-1), 2^(W-1)-1]
//   ovf  : 1 when the clamp was applied
module sat_add_s #(
    parameter int W = 12
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                ovf
);

    logic signed [W-1:0] raw;

    assign raw = a + b;
    // Overflow only when both operands share a sign the wrapped sum lost.
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

    always_comb begin
        y = raw;
        if (ovf) begin
            y = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/prod_accum_6.sv
// Saturating group accumulator for the signed 6-bit adder_6 result stream.
// Beats are summed into an ACC_W-bit accumulator until in_last or the
// MAX_CNT-th beat closes the group; the sum, beat count and sticky
// saturation flag are then held on the output port until taken.
// Input and output never overlap: in_ready is low while a result is held.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : slave side of prod_accum_6_if (beats in, groups out)
//   dbg_state : current group state
module prod_accum_6
    import prod_accum_pkg::*;
#(
    parameter int ACC_W   = 12,
    parameter int MAX_CNT = 16,
    localparam int CNT_W  = $clog2(MAX_CNT + 1)
) (
    input  logic           clk,
    input  logic           rst,
    prod_accum_6_if.slave  bus,
    output state_t         dbg_state
);

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, acc_upd, in_ext, add_y;
    logic [CNT_W-1:0]        cnt, cnt_upd;
    logic                    sat, sat_upd, add_ovf;
    logic                    beat, close, take;

    assign in_ext = ACC_W'(sext_in(bus.in_data));

    sat_add_s #(.W(ACC_W)) u_add (
        .a   (acc),
        .b   (in_ext),
        .y   (add_y),
        .ovf (add_ovf)
    );

    assign beat  = bus.in_valid && bus.in_ready;
    assign take  = (state == HOLD) && bus.out_ready;
    assign close = beat && (bus.in_last || (cnt_upd == CNT_W'(MAX_CNT)));

    // Group registers as they would be after accepting the current beat.
    // The first beat of a group loads rather than adds, so it cannot clamp.
    always_comb begin
        acc_upd = add_y;
        cnt_upd = cnt + CNT_W'(1);
        sat_upd = sat | add_ovf;
        if (state == IDLE) begin
            acc_upd = in_ext;
            cnt_upd = CNT_W'(1);
            sat_upd = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (close)     state_nxt = HOLD;
                else if (beat) state_nxt = ACCUM;
            end
            HOLD: begin
                if (take) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = (state != HOLD);
        bus.out_valid = (state == HOLD);
        dbg_state     = state;
    end

    // Group datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc           <= '0;
            cnt           <= '0;
            sat           <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_count <= '0;
            bus.out_sat   <= 1'b0;
        end else if (take) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (beat) begin
            acc <= acc_upd;
            cnt <= cnt_upd;
            sat <= sat_upd;
            if (close) begin
                bus.out_sum   <= acc_upd;
                bus.out_count <= cnt_upd;
                bus.out_sat   <= sat_upd;
            end
        end
    end

endmodule

// File: doc/prod_accum_6.md
Name: prod_accum_6

Overview:
- Downstream consumer of the 6-bit signed result bus `C` from the Dadda multiplier's final adder stage, adder_6.
- Accumulates a group of signed 6-bit results into a wider saturating accumulator.
- Closes a group on an explicit last flag or after MAX_CNT beats, then presents the sum, beat count and a saturation flag on a valid/ready output port.

Parameters:
- ACC_W, 12, accumulator and out_sum width in bits; must be at least 6.
- MAX_CNT, 16, maximum beats per group; the group auto-closes on the MAX_CNT-th accepted beat.
- CNT_W, $clog2(MAX_CNT+1), width of out_count (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_data/in_last are valid this cycle.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  6  signed two's-complement result, from adder_6 C.
- in_last  input  1  this beat closes the current group.
- out_valid  output  1  out_sum/out_count/out_sat hold a completed group.
- out_ready  input  1  downstream accepts the completed group.
- out_sum  output  ACC_W  signed accumulated sum of the group.
- out_count  output  CNT_W  number of beats in the group, 1..MAX_CNT.
- out_sat  output  1  sticky: saturation occurred at least once in this group.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, acc=0, cnt=0, sat=0, out_valid=0, out_sum=0, out_count=0, out_sat=0. in_ready is 1 in the first cycle after reset.
- Beat acceptance: a beat is accepted when in_valid && in_ready. in_ready=1 in IDLE and ACCUM, 0 in HOLD. No input/output overlap; the block is half-duplex by design.
- Arithmetic: in_data is sign-extended to ACC_W and added to acc with saturation.
  - Overflow: operand signs are equal and the result sign differs.
  - Positive overflow clamps to 2^(ACC_W-1)-1; negative overflow clamps to -2^(ACC_W-1).
  - Any clamp sets sat for the rest of the group.
- First beat of a group: the beat accepted in IDLE loads acc = sext(in_data) and cnt=1. Saturation is impossible on this beat.
- Group close: the closing beat is included in the sum. A group closes on an accepted beat when in_last=1 or cnt+1 == MAX_CNT. On close, the registered result goes to out_* and the state moves to HOLD.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- State machine:
  - IDLE -> ACCUM on an accepted beat that does not close the group.
  - IDLE -> HOLD on an accepted beat that closes it (in_last=1, or MAX_CNT==1).
  - ACCUM -> ACCUM on a non-closing accepted beat; ACCUM -> HOLD on a closing accepted beat.
  - ACCUM with no beat: hold all state; no timeout.
  - HOLD: out_valid=1 and out_* stable until out_ready=1. On the handshake: out_valid=0, acc/cnt/sat cleared, state -> IDLE.
- out_sum/out_count/out_sat after the handshake: retain last values, don't-care while out_valid=0, and are not checked then.
- Boundary conditions:
  - in_last is ignored when in_valid=0.
  - out_ready is ignored outside HOLD.
  - in_data=-32 is legal.
  - rst in any state discards the partial group or the held result; no output is produced for it.
  - rst has priority over every handshake in the same cycle.

Decomposition:
- Shared package prod_accum_pkg:
  - state enum {IDLE, ACCUM, HOLD};
  - localparam IN_W=6;
  - a function for sign-extension to ACC_W.
- One natural sub-module, sat_add_s, parameterised by width W. It is combinational, takes a W-bit signed a and b, and returns the saturated sum plus an ovf flag.
- The state machine, counter and output registers stay in prod_accum_6.

Test Plan:
- Defaults; in_data=-31 with in_last=1, out_ready=1 -> out_valid=1 the next cycle, out_sum=12'hFE1 (-31), out_count=1, out_sat=0. Back to IDLE the cycle after.
- Beats 16, 8, -8, -9, in_last on the 4th -> out_sum=7, out_count=4, out_sat=0. in_ready=1 throughout accumulation.
- 16 beats of 31, in_last never asserted -> auto-close on the 16th beat: out_sum=496, out_count=16, out_sat=0.
- ACC_W=8: 16 beats of 31 -> out_sum=127, out_sat=1. Then a new group of 5 beats of -32 with last -> out_sum=-128, out_sat=1. The clamp occurs on the 5th beat.
- Backpressure: after a close, hold out_ready=0 for 5 cycles while driving in_valid=1 -> out_* stable and in_ready=0 for all 5 cycles. Then out_ready=1 -> handshake, and the next beat is accepted as a fresh group with cnt=1.
- Reset mid-group: 3 beats of 10, then rst=1 for 1 cycle -> no out_valid. Next group of 2 beats, 1 and 2 with last -> out_sum=3, out_count=2. Also assert rst during HOLD -> out_valid=0 the next cycle.
